// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM arbiter
package sram_arb_pkg;

    localparam int DATA_W      = 16;
    localparam int SYNC_CYCLES = 4;
    localparam int WDOG_LIMIT  = 15;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_WR_ISSUE,
        ST_WR_WAIT,
        ST_RD_WAIT,
        ST_CL_ISSUE,
        ST_CL_WAIT
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - round-robin picker: first valid index strictly after last, wrapping
module rr_picker #(
    parameter int NREQ = 3,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDXW-1:0] last,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    logic [IDXW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDXW'((int'(last) + k) % NREQ);
            if (!any && valid[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin SRAM controller arbiter with clean service; optional SRAM_ARB_WATCHDOG_EN
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DEPTH     = 19,
    parameter int NREQ      = 3,
    parameter int READ_WAIT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_write,
    input  logic [NREQ*(DEPTH+1)-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0]    req_wdata,
    output logic [NREQ-1:0]           req_gnt,
    output logic [NREQ-1:0]           req_done,
    output logic [DATA_W-1:0]         rdata,
    input  logic                      clean_all,
    input  logic                      clean_mark,
    output logic                      clean_busy,
    output logic                      busy,
    output logic                      err,
    output logic [DEPTH:0]            ctl_addr,
    output logic                      ctl_write_en,
    output logic                      ctl_clear,
    output logic                      ctl_clean_mark,
    output logic [DATA_W-1:0]         ctl_wdata,
    input  logic [DATA_W-1:0]         ctl_rdata,
    input  logic                      ctl_ready
);

    localparam int AW   = DEPTH + 1;
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state;
    logic [2:0]      sync_cnt;
    logic [7:0]      rd_cnt;
    logic [IDXW-1:0] last_idx;
    logic [IDXW-1:0] cur_idx;
    logic            pend_all;
    logic            pend_mark;

    logic [NREQ-1:0] pick_gnt;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;
    logic            grant_ok;
    logic [NREQ-1:0] done_mask;

    rr_picker #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .valid (req_valid),
        .last  (last_idx),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Requesters only see a grant in IDLE with no clean waiting its turn.
    assign grant_ok   = (state == ST_IDLE) && !pend_all && !pend_mark;
    assign req_gnt    = grant_ok ? pick_gnt : '0;
    assign done_mask  = NREQ'(1) << cur_idx;
    assign busy       = (state != ST_IDLE);
    assign clean_busy = (state == ST_CL_ISSUE) || (state == ST_CL_WAIT);

`ifdef SRAM_ARB_WATCHDOG_EN
    logic [3:0] wd_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_SYNC;
            sync_cnt       <= '0;
            rd_cnt         <= '0;
            last_idx       <= IDXW'(NREQ - 1);
            cur_idx        <= '0;
            pend_all       <= 1'b0;
            pend_mark      <= 1'b0;
            req_done       <= '0;
            rdata          <= '0;
            ctl_addr       <= '0;
            ctl_wdata      <= '0;
            ctl_write_en   <= 1'b0;
            ctl_clear      <= 1'b0;
            ctl_clean_mark <= 1'b0;
`ifdef SRAM_ARB_WATCHDOG_EN
            wd_cnt         <= '0;
            err            <= 1'b0;
`endif
        end else begin
            req_done       <= '0;
            ctl_write_en   <= 1'b0;
            ctl_clear      <= 1'b0;
            ctl_clean_mark <= 1'b0;
            if (clean_all) pend_all <= 1'b1;
            if (clean_mark) pend_mark <= 1'b1;

            case (state)
                ST_SYNC: begin
                    if (sync_cnt == 3'(SYNC_CYCLES - 1)) state <= ST_IDLE;
                    else sync_cnt <= sync_cnt + 3'd1;
                end
                ST_IDLE: begin
                    // A pulse of the kind being started merges into that clean.
                    if (pend_all) begin
                        pend_all  <= 1'b0;
                        ctl_clear <= 1'b1;
                        state     <= ST_CL_ISSUE;
                    end else if (pend_mark) begin
                        pend_mark      <= 1'b0;
                        ctl_clean_mark <= 1'b1;
                        state          <= ST_CL_ISSUE;
                    end else if (pick_any) begin
                        cur_idx   <= pick_idx;
                        last_idx  <= pick_idx;
                        ctl_addr  <= req_addr[int'(pick_idx)*AW +: AW];
                        ctl_wdata <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                        if (req_write[pick_idx]) begin
                            ctl_write_en <= 1'b1;
                            state        <= ST_WR_ISSUE;
                        end else begin
                            rd_cnt <= 8'(READ_WAIT - 1);
                            state  <= ST_RD_WAIT;
                        end
                    end
                end
                ST_WR_ISSUE: begin
                    state <= ST_WR_WAIT;
`ifdef SRAM_ARB_WATCHDOG_EN
                    wd_cnt <= 4'd1;
`endif
                end
                ST_WR_WAIT: begin
                    if (ctl_ready) begin
                        req_done <= done_mask;
                        state    <= ST_IDLE;
                    end
`ifdef SRAM_ARB_WATCHDOG_EN
                    // Counter started in WR_ISSUE, so the limit is measured from the write strobe.
                    else if (wd_cnt == 4'(WDOG_LIMIT - 1)) begin
                        err      <= 1'b1;
                        req_done <= done_mask;
                        sync_cnt <= '0;
                        state    <= ST_SYNC;
                    end else begin
                        wd_cnt <= wd_cnt + 4'd1;
                    end
`endif
                end
                ST_RD_WAIT: begin
                    if (rd_cnt == 8'd0) begin
                        rdata    <= ctl_rdata;
                        req_done <= done_mask;
                        state    <= ST_IDLE;
                    end else begin
                        rd_cnt <= rd_cnt - 8'd1;
                    end
                end
                ST_CL_ISSUE: state <= ST_CL_WAIT;
                ST_CL_WAIT: begin
                    if (ctl_ready) state <= ST_IDLE;
                end
                default: state <= ST_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter against a transaction-level timeline model
module tb_sram_arbiter;

    localparam int DEPTH = 19;
    localparam int NREQ  = 3;
    localparam int RW    = 2;
    localparam int AW    = DEPTH + 1;
    localparam int MAXC  = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NREQ-1:0] req_valid = '0, req_write = '0, req_gnt, req_done;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*16-1:0] req_wdata = '0;
    logic [15:0] rdata, ctl_wdata;
    logic [15:0] ctl_rdata = '0;
    logic clean_all = 1'b0, clean_mark = 1'b0, clean_busy, busy, err;
    logic [AW-1:0] ctl_addr;
    logic ctl_write_en, ctl_clear, ctl_clean_mark;
    logic ctl_ready = 1'b0;

    always #5 clk = ~clk;

    sram_arbiter #(.DEPTH(DEPTH), .NREQ(NREQ), .READ_WAIT(RW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_gnt(req_gnt), .req_done(req_done),
        .rdata(rdata), .clean_all(clean_all), .clean_mark(clean_mark), .clean_busy(clean_busy),
        .busy(busy), .err(err), .ctl_addr(ctl_addr), .ctl_write_en(ctl_write_en),
        .ctl_clear(ctl_clear), .ctl_clean_mark(ctl_clean_mark), .ctl_wdata(ctl_wdata),
        .ctl_rdata(ctl_rdata), .ctl_ready(ctl_ready)
    );

    int n_chk = 0, n_fail = 0, cyc = 0;

    // requester and stimulus controls
    bit rv[NREQ];
    bit rw[NREQ];
    bit [AW-1:0] ra[NREQ];
    bit [15:0] rd[NREQ];
    bit rst_req = 1, random_mode = 0, sticky = 0, noready = 0, pulse_all = 0, pulse_mark = 0;
    int force_r = 0;

    // model: timeline of expected events per cycle
    int free_at = 0, wc_until = 0, m_last = NREQ - 1;
    bit p_all = 0, p_mark = 0, m_err = 0;
    bit [15:0] m_rdata = 0;
    bit [NREQ-1:0] e_done[MAXC];
    bit e_we[MAXC], e_clr[MAXC], e_mrk[MAXC], e_cb[MAXC], rdy[MAXC], rcap[MAXC], e_rdv[MAXC], e_errs[MAXC];
    bit [AW-1:0] e_wa[MAXC];
    bit [15:0] e_wd[MAXC], e_rdval[MAXC];
    bit [15:0] rmem[int];
    bit [15:0] cmem[int];

    // observed events for directed checks
    int ev_gnt_c, ev_done_c, ev_we_c, ev_clr_c, ev_mrk_c, ev_cbf_c;
    logic [NREQ-1:0] ev_gnt_v, ev_done_v;
    logic [15:0] ev_rdata;
    logic [NREQ-1:0] gq[$];
    bit prev_cb = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int pick(input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (rv[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit [AW-1:0] rnd_addr();
        return AW'(($urandom_range(1) << (AW - 1)) | $urandom_range(7));
    endfunction

    function automatic bit [15:0] mem_rd(input bit ctl_side, input int a);
        if (ctl_side) return cmem.exists(a) ? cmem[a] : 16'h0;
        return rmem.exists(a) ? rmem[a] : 16'h0;
    endfunction

    task automatic wipe(input bit ctl_side, input bit mark_only);
        int keys[$];
        if (ctl_side) begin
            foreach (cmem[k]) if (!mark_only || ((k >> (AW - 1)) & 1) != 0) keys.push_back(k);
            foreach (keys[j]) cmem.delete(keys[j]);
        end else begin
            foreach (rmem[k]) if (!mark_only || ((k >> (AW - 1)) & 1) != 0) keys.push_back(k);
            foreach (keys[j]) rmem.delete(keys[j]);
        end
    endtask

    task automatic clear_ev();
        ev_gnt_c = -1; ev_done_c = -1; ev_we_c = -1; ev_clr_c = -1; ev_mrk_c = -1; ev_cbf_c = -1;
        ev_gnt_v = '0; ev_done_v = '0; ev_rdata = '0;
        gq.delete();
    endtask

    task automatic model_reset(input int c);
        free_at = c + 5; wc_until = 0; m_last = NREQ - 1;
        p_all = 0; p_mark = 0; m_rdata = 0; m_err = 0;
        for (int k = c + 1; k < c + 40 && k < MAXC; k++) begin
            e_done[k] = '0; e_we[k] = 0; e_clr[k] = 0; e_mrk[k] = 0; e_cb[k] = 0;
            rdy[k] = 0; rcap[k] = 0; e_rdv[k] = 0; e_errs[k] = 0;
        end
    endtask

    task automatic step();
        int c, gi, r;
        logic [NREQ-1:0] eg;
        bit srv_all, srv_mark;
        @(posedge clk);
        cyc++;
        c = cyc;
        #1;
        rst = rst_req;
        if (random_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!rv[i] && $urandom_range(2) == 0) begin
                    rv[i] = 1; rw[i] = 1'($urandom_range(1)); ra[i] = rnd_addr(); rd[i] = 16'($urandom);
                end
            end
            if ($urandom_range(199) == 0) pulse_all = 1;
            if ($urandom_range(149) == 0) pulse_mark = 1;
        end
        if (sticky) for (int i = 0; i < NREQ; i++) rv[i] = 1;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = rv[i];
            req_write[i] = rw[i];
            req_addr[i*AW +: AW] = ra[i];
            req_wdata[i*16 +: 16] = rd[i];
        end
        clean_all = pulse_all;
        clean_mark = pulse_mark;
        ctl_ready = rdy[c] || (c >= wc_until && $urandom_range(3) == 0);
        ctl_rdata = rcap[c] ? mem_rd(1, int'(ctl_addr)) : 16'($urandom);
        @(negedge clk);
        if (ctl_write_en === 1'b1) cmem[int'(ctl_addr)] = ctl_wdata;
        if (ctl_clear === 1'b1) wipe(1, 0);
        if (ctl_clean_mark === 1'b1) wipe(1, 1);
        if (rst) begin
            model_reset(c);
        end else begin
            eg = '0;
            gi = -1;
            if (c >= free_at && !p_all && !p_mark) begin
                gi = pick(m_last);
                if (gi >= 0) eg[gi] = 1'b1;
            end
            if (e_rdv[c]) m_rdata = e_rdval[c];
            if (e_errs[c]) m_err = 1;
            check("req_gnt", req_gnt, eg);
            check("req_done", req_done, e_done[c]);
            check("ctl_write_en", ctl_write_en, e_we[c]);
            if (e_we[c]) begin
                check("ctl_addr", ctl_addr, e_wa[c]);
                check("ctl_wdata", ctl_wdata, e_wd[c]);
            end
            check("ctl_clear", ctl_clear, e_clr[c]);
            check("ctl_clean_mark", ctl_clean_mark, e_mrk[c]);
            check("clean_busy", clean_busy, e_cb[c]);
            check("busy", busy, c < free_at);
            check("rdata", rdata, m_rdata);
            check("err", err, m_err);

            if (req_gnt != 0 && ev_gnt_c < 0) begin ev_gnt_c = c; ev_gnt_v = req_gnt; end
            if (req_gnt != 0 && gq.size() < 8) gq.push_back(req_gnt);
            if (req_done != 0 && ev_done_c < 0) begin ev_done_c = c; ev_done_v = req_done; ev_rdata = rdata; end
            if (ctl_write_en && ev_we_c < 0) ev_we_c = c;
            if (ctl_clear && ev_clr_c < 0) ev_clr_c = c;
            if (ctl_clean_mark && ev_mrk_c < 0) ev_mrk_c = c;
            if (prev_cb && !clean_busy && ev_cbf_c < 0) ev_cbf_c = c;
            prev_cb = clean_busy;

            srv_all = 0;
            srv_mark = 0;
            if (c >= free_at) begin
                if (p_all || p_mark) begin
                    r = (force_r != 0) ? force_r : int'($urandom_range(6, 2));
                    if (p_all) begin
                        e_clr[c+1] = 1; srv_all = 1; p_all = 0; wipe(0, 0);
                    end else begin
                        e_mrk[c+1] = 1; srv_mark = 1; p_mark = 0; wipe(0, 1);
                    end
                    for (int k = 1; k <= r; k++) e_cb[c+k] = 1;
                    rdy[c+r] = 1;
                    free_at = c + r + 1;
                    wc_until = free_at;
                end else if (gi >= 0) begin
                    m_last = gi;
                    rv[gi] = 0;
                    if (rw[gi]) begin
                        rmem[int'(ra[gi])] = rd[gi];
                        e_we[c+1] = 1; e_wa[c+1] = ra[gi]; e_wd[c+1] = rd[gi];
                        if (noready) begin
`ifdef SRAM_ARB_WATCHDOG_EN
                            e_done[c+16] = eg; e_errs[c+16] = 1;
                            free_at = c + 20; wc_until = c + 16;
`else
                            free_at = c + 100000; wc_until = free_at;
`endif
                        end else begin
                            r = (force_r != 0) ? force_r : int'($urandom_range(5, 2));
                            rdy[c+r] = 1;
                            e_done[c+r+1] = eg;
                            free_at = c + r + 1;
                            wc_until = free_at;
                        end
                    end else begin
                        e_done[c+RW+1] = eg;
                        e_rdv[c+RW+1] = 1;
                        e_rdval[c+RW+1] = mem_rd(0, int'(ra[gi]));
                        rcap[c+RW] = 1;
                        free_at = c + RW + 1;
                    end
                end
            end
            if (pulse_all && !srv_all) p_all = 1;
            if (pulse_mark && !srv_mark) p_mark = 1;
        end
        pulse_all = 0;
        pulse_mark = 0;
    endtask

    initial begin
        int rel;
        clear_ev();
        // reset with every requester asking, then round-robin order
        for (int i = 0; i < NREQ; i++) begin rv[i] = 1; rw[i] = 0; ra[i] = AW'(i); rd[i] = 0; end
        sticky = 1;
        rst_req = 1;
        step();
        step();
        rst_req = 0;
        rel = cyc + 1;
        repeat (25) step();
        check("sync_len", ev_gnt_c - rel, 4);
        while (gq.size() < 4) gq.push_back('0);
        check("rr_0", gq[0], 3'b001);
        check("rr_1", gq[1], 3'b010);
        check("rr_2", gq[2], 3'b100);
        check("rr_3", gq[3], 3'b001);
        sticky = 0;
        for (int i = 0; i < NREQ; i++) rv[i] = 0;
        repeat (6) step();

        // write then read back
        force_r = 3;
        clear_ev();
        rv[1] = 1; rw[1] = 1; ra[1] = 20'h00012; rd[1] = 16'hBEEF;
        repeat (8) step();
        check("wr_en_lat", ev_we_c - ev_gnt_c, 1);
        check("wr_done_lat", ev_done_c - ev_gnt_c, 4);
        check("wr_done_who", ev_done_v, 3'b010);
        clear_ev();
        rv[2] = 1; rw[2] = 0; ra[2] = 20'h00012;
        repeat (8) step();
        check("rd_done_lat", ev_done_c - ev_gnt_c, 3);
        check("rd_done_who", ev_done_v, 3'b100);
        check("rd_data", ev_rdata, 16'hBEEF);

        // both clean pulses during an active read
        clear_ev();
        rv[0] = 1; rw[0] = 0; ra[0] = 20'h00005;
        step();
        pulse_all = 1;
        pulse_mark = 1;
        repeat (20) step();
        check("cl_done_who", ev_done_v, 3'b001);
        check("cl_after_done", ev_clr_c - ev_done_c, 1);
        check("mark_after_clr", ev_mrk_c - ev_clr_c, 4);

        // requester held across a clean
        clear_ev();
        pulse_all = 1;
        step();
        rv[2] = 1; rw[2] = 0; ra[2] = 20'h80001;
        repeat (12) step();
        check("hold_gnt_at_fall", ev_gnt_c - ev_cbf_c, 0);
        check("hold_gnt_lat", ev_gnt_c - ev_clr_c, 3);
        check("hold_gnt_who", ev_gnt_v, 3'b100);
        force_r = 0;

        // withheld ready, then reset while the write is outstanding
        clear_ev();
        noready = 1;
        rv[0] = 1; rw[0] = 1; ra[0] = 20'h00007; rd[0] = 16'h1234;
        repeat (30) step();
`ifdef SRAM_ARB_WATCHDOG_EN
        check("wdog_lat", ev_done_c - ev_we_c, 15);
        check("wdog_err", err, 1'b1);
`else
        check("stall_no_done", ev_done_c, -1);
        check("stall_busy", busy, 1'b1);
        check("stall_err", err, 1'b0);
`endif
        noready = 0;
        rst_req = 1;
        step();
        rst_req = 0;
        step();
        check("rst_ctl_addr", ctl_addr, '0);
        check("rst_ctl_wdata", ctl_wdata, '0);
        check("rst_busy", busy, 1'b1);
        check("rst_err", err, 1'b0);

        // randomized traffic
        random_mode = 1;
        repeat (1500) step();
        random_mode = 0;
        repeat (40) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single-port SRAM controller among NREQ board-logic requesters (move engine, tile checker, display scanner) plus a clear/clean-mark service. Arbitrates round-robin, sequences each transaction into the controller's write/ready protocol, paces reads, and returns per-requester completion strobes. Sits directly between the game datapath and the SRAM controller.

## Interface
- DEPTH, 19, SRAM address MSB; addresses are DEPTH+1 bits
- NREQ, 3, number of requesters (2..8)
- READ_WAIT, 2, cycles the read address is held before data capture (≥1)
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  request pending, held until req_gnt
- req_write  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*(DEPTH+1)  packed addresses, requester i at slice i
- req_wdata  in  NREQ*16  packed write data
- req_gnt  out  NREQ  one-hot, one-cycle accept pulse
- req_done  out  NREQ  one-hot, one-cycle completion pulse
- rdata  out  16  read data, valid on the req_done cycle of a read, held until next read
- clean_all  in  1  pulse: zero the whole SRAM
- clean_mark  in  1  pulse: zero the mark half only
- clean_busy  out  1  clean in progress
- busy  out  1  FSM not in IDLE
- err  out  1  sticky watchdog flag, cleared only by rst
- ctl_addr  out  DEPTH+1  to controller addr
- ctl_write_en, ctl_clear, ctl_clean_mark  out  1  to controller write_en, rst, clean_mark
- ctl_wdata  out  16  to controller data_in
- ctl_rdata  in  16  from controller data_out
- ctl_ready  in  1  from controller ready

## Operation
- States: SYNC, IDLE, WR_ISSUE, WR_WAIT, RD_WAIT, CL_ISSUE, CL_WAIT.
- SYNC: entered on rst; lasts 4 cycles so any in-flight controller write retires; then IDLE. A clean running at reset is abandoned; the system never resets during a clean.
- IDLE priority: pending clean (clean_all over clean_mark if both) > requesters. Clean pulses arriving while busy are latched (one pending flag each) and served at the next IDLE.
- Round-robin: grant the first valid index strictly after last-granted, wrapping; last-granted resets to NREQ-1 (index 0 wins first).
- Grant: req_gnt[i] pulses in the IDLE cycle of selection; address, write flag and wdata are captured into registers on that edge; ctl_* are driven from the registers only.
- Write: WR_ISSUE drives ctl_write_en=1 for exactly one cycle; WR_WAIT keeps addr/data and waits for ctl_ready; then req_done[i], IDLE.
- Read: RD_WAIT holds ctl_addr READ_WAIT cycles (counter), captures ctl_rdata into rdata on the last cycle, pulses req_done[i], IDLE.
- Clean: CL_ISSUE asserts ctl_clear or ctl_clean_mark for one cycle; CL_WAIT until ctl_ready; clean_busy high in both states.
- ctl_ready seen in IDLE or RD_WAIT is ignored.
- Reset values: req_gnt=0, req_done=0, rdata=0, clean_busy=0, busy=1 (SYNC), err=0, all ctl_* = 0.

## Timing
- Write: gnt at T, ctl_write_en at T+1, ctl_ready at T+3, req_done at T+4; next grant possible at T+4 (IDLE).
- Read: gnt at T, req_done and rdata at T+READ_WAIT+1.
- Back-to-back grants are never in adjacent cycles; at least one issue/wait state separates them.
- Clean latency is controller-bound (~2^(DEPTH+1) cycles); requesters stall with req_valid held.

## Configuration
- SRAM_ARB_WATCHDOG_EN defined: 4-bit counter in WR_WAIT/CL_WAIT excluded for CL_WAIT; if ctl_ready absent 15 cycles after WR_ISSUE, set err, pulse req_done[i], enter SYNC.
- Undefined: WR_WAIT waits indefinitely; err tied to 0.

## Structure
- Package sram_arb_pkg: state enum, SYNC_CYCLES=4, WDOG_LIMIT=15, data width 16.
- One sub-module rr_picker (NREQ valid bits + last index → one-hot grant + index), reusable by other arbiters.

## Test plan
- After rst: busy=1 for 4 cycles, no gnt despite req_valid=3'b111; then gnt order 001, 010, 100, 001.
- Write req 1, addr 0x00012, data 0xBEEF: ctl_write_en one cycle at T+1, req_done[1] at T+4; read back by req 2 gives rdata=0xBEEF at T+3 (READ_WAIT=2).
- clean_all and clean_mark same cycle while requester 0 active: req_done[0] first, then ctl_clear only, clean_busy until ctl_ready, clean_mark pending served next.
- Requester 2 holds req_valid through a clean: no gnt until clean_busy falls, gnt in the next IDLE cycle.
- Watchdog build, model withholds ctl_ready: err=1 and req_done pulses 15 cycles after WR_ISSUE, stays 1 until rst; non-watchdog build stays in WR_WAIT.
- rst asserted in WR_WAIT: next cycle all outputs at reset values, state SYNC.
